wind_lights_n: RTL

Parametrised, rate-controlled successor to the 3-LED wind-pattern FSM. It drives an N-wide LEDR bar in one of three animated patterns selected by SW: calm, wind blowing left, or wind blowing right. A fourth SW code freezes the pattern. Pattern updates occur once every TICK_DIV clocks, so the animation is visible at board clock rates without an external divider. It sits between the board switches and the LEDR bank in the top-level, alongside the tug-of-war playfield.

---
 rtl/wind_lights_pkg.sv | 33 +++
 rtl/wind_lights_n_step_divider.sv | 41 ++++
 rtl/wind_lights_n.sv | 88 ++++++++
 3 files changed

// File: rtl/wind_lights_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wind_lights_pkg
// Description : Shared types and pattern helpers for the wind-light bar.
//               mode_t encodes the SW mode select. center_pat/edges_pat build
//               the named patterns for an N-wide bar. They return a c_MAX_N
//               wide vector, so callers truncate the result to their own width.
// Revision    : 1.0 - initial release
// ============================================================================
package wind_lights_pkg;

    typedef enum logic [1:0] {
        MODE_CALM  = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10,
        MODE_HOLD  = 2'b11
    } mode_t;

    // Widest bar the helper functions can describe.
    localparam int c_MAX_N = 64;

    // Only bit n/2 set.
    function automatic logic [c_MAX_N-1:0] center_pat(input int n);
        return c_MAX_N'(1) << (n / 2);
    endfunction

    // Bits 0 and n-1 set.
    function automatic logic [c_MAX_N-1:0] edges_pat(input int n);
        return c_MAX_N'(1) | (c_MAX_N'(1) << (n - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/wind_lights_n_step_divider.sv
`default_nettype none
// ============================================================================
// Module      : step_divider
// Description : Free-running 0..TICK_DIV-1 counter. tick is combinational and
//               is high for the whole cycle in which the counter sits at
//               TICK_DIV-1, so the following rising edge is the wrap edge.
//               With TICK_DIV=1, tick is high every cycle.
// Ports       : clk   - system clock
//               reset - synchronous active-high reset, clears the counter
//               tick  - high during the wrap cycle
// Revision    : 1.0 - initial release
// ============================================================================
module step_divider #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int c_CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(TICK_DIV - 1);

    logic [c_CW-1:0] r_count;
    logic            w_wrap;

    assign w_wrap = (r_count == c_LAST);
    assign tick   = w_wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/wind_lights_n.sv
`default_nettype none
// ============================================================================
// Module      : wind_lights_n
// Description : N-wide animated wind-light bar. On each step edge of the
//               internal divider, LEDR advances according to SW: calm
//               alternates CENTER/EDGES, left and right rotate a single lit
//               LED, and hold freezes the bar. Between step edges LEDR holds.
// Ports       : clk   - system clock
//               reset - synchronous active-high reset
//               SW    - mode select, sampled only on step edges
//               LEDR  - registered light pattern
//               step  - registered one-cycle pulse after each step edge
// Revision    : 1.0 - initial release
// ============================================================================
module wind_lights_n
    import wind_lights_pkg::*;
#(
    parameter int N        = 3,
    parameter int TICK_DIV = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   SW,
    output logic [N-1:0] LEDR,
    output logic         step
);

    generate
        if (N < 3 || (N % 2) == 0 || N > c_MAX_N) begin : g_bad_n
            $error("wind_lights_n: N must be odd, at least 3 and at most c_MAX_N");
        end
        if (TICK_DIV < 1) begin : g_bad_div
            $error("wind_lights_n: TICK_DIV must be at least 1");
        end
    endgenerate

    localparam logic [N-1:0] c_CENTER = N'(center_pat(N));
    localparam logic [N-1:0] c_EDGES  = N'(edges_pat(N));
    localparam logic [N-1:0] c_BIT0   = N'(1);
    localparam logic [N-1:0] c_BITTOP = c_BIT0 << (N - 1);

    logic [N-1:0] r_ledr;
    logic         r_step;
    logic         w_tick;
    logic [N-1:0] w_next;
    mode_t        w_mode;

    step_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    assign w_mode = mode_t'(SW);

    // Next pattern. Values outside the reachable set (e.g. all-zero, several
    // bits lit) fall into the non-CENTER / non-one-hot branches and recover.
    always_comb begin
        w_next = r_ledr;
        case (w_mode)
            MODE_CALM:  w_next = (r_ledr == c_CENTER) ? c_EDGES : c_CENTER;
            MODE_LEFT:  w_next = $onehot(r_ledr) ? {r_ledr[N-2:0], r_ledr[N-1]} : c_BIT0;
            MODE_RIGHT: w_next = $onehot(r_ledr) ? {r_ledr[0], r_ledr[N-1:1]} : c_BITTOP;
            MODE_HOLD:  w_next = r_ledr;
            default:    w_next = r_ledr;
        endcase
    end

    // Reset takes priority over a coincident step edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ledr <= c_CENTER;
            r_step <= 1'b0;
        end else begin
            r_step <= w_tick;
            if (w_tick) begin
                r_ledr <= w_next;
            end
        end
    end

    assign LEDR = r_ledr;
    assign step = r_step;

endmodule
`default_nettype wire
